tdp18k_fifo_ctrl: RTL

- Synchronous first-word-fall-through FIFO controller that drives one 18Kb half (RAM 1 or RAM 2) of TDP_RAM18KX2, configured 18-bit wide on both ports.
- Port A is the write side; port B is the read side. The RAM's 1-cycle registered read is hidden behind a 2-entry output buffer, so the pop side sees a plain valid/ready stream.
- Sits directly upstream of TDP_RAM18KX2 and owns all of its port-A/B control, address and data pins.

---
 rtl/tdp18k_fifo_pkg.sv | 22 ++
 rtl/tdp18k_fifo_ctrl_if.sv | 27 ++
 rtl/fifo_out_skid.sv | 58 +++++
 rtl/tdp18k_fifo_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/tdp18k_fifo_pkg.sv
// Shared constants and types for the TDP_RAM18KX2 FIFO controller.
package tdp18k_fifo_pkg;

    localparam int FIFO_DEPTH   = 1024;
    localparam int PTR_W        = 10;
    localparam int CNT_W        = 11;
    localparam int ADDR_LSB_PAD = 4;
    localparam int ADDR_W       = PTR_W + ADDR_LSB_PAD;
    localparam int WORD_W       = 18;

    // One FIFO word as stored in the 18-bit RAM port: {parity, data}.
    typedef struct packed {
        logic [1:0]  parity;
        logic [15:0] data;
    } fifo_word_t;

    // RAM word address sits above the 4 byte/bit-select LSBs of the macro address.
    function automatic logic [ADDR_W-1:0] ram_addr(input logic [PTR_W-1:0] ptr);
        return {ptr, {ADDR_LSB_PAD{1'b0}}};
    endfunction

endpackage

// File: rtl/tdp18k_fifo_ctrl_if.sv
// Push/pop stream and status bundle of the FIFO controller.
interface tdp18k_fifo_ctrl_if;
    import tdp18k_fifo_pkg::*;

    fifo_word_t       WR_DATA;
    logic             WR_VALID;
    logic             WR_READY;
    fifo_word_t       RD_DATA;
    logic             RD_VALID;
    logic             RD_READY;
    logic [CNT_W-1:0] COUNT;
    logic             ALMOST_FULL;
    logic             ALMOST_EMPTY;

    // Producer/consumer side.
    modport master (
        output WR_DATA, WR_VALID, RD_READY,
        input  WR_READY, RD_DATA, RD_VALID, COUNT, ALMOST_FULL, ALMOST_EMPTY
    );

    // FIFO controller side.
    modport slave (
        input  WR_DATA, WR_VALID, RD_READY,
        output WR_READY, RD_DATA, RD_VALID, COUNT, ALMOST_FULL, ALMOST_EMPTY
    );

endinterface

// File: rtl/fifo_out_skid.sv
// Two-entry output buffer hiding the RAM's registered read; head register drives the pop port.
module fifo_out_skid
    import tdp18k_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       cap,
    input  fifo_word_t cap_data,
    input  logic       pop,
    output fifo_word_t head,
    output logic       head_vld,
    output logic [1:0] buf_cnt
);

    fifo_word_t tail;

    assign head_vld = (buf_cnt != 2'd0);

    // Occupancy/data update; the read issuer guarantees no capture into a full buffer without a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            buf_cnt <= 2'd0;
        end else if (clr) begin
            buf_cnt <= 2'd0;
        end else begin
            case (buf_cnt)
                2'd0: begin
                    if (cap) begin
                        head    <= cap_data;
                        buf_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({cap, pop})
                        2'b11: head <= cap_data;
                        2'b10: begin
                            tail    <= cap_data;
                            buf_cnt <= 2'd2;
                        end
                        2'b01: buf_cnt <= 2'd0;
                        default: ;
                    endcase
                end
                default: begin
                    if (pop) begin
                        head <= tail;
                        if (cap) tail <= cap_data;
                        else     buf_cnt <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/tdp18k_fifo_ctrl.sv
// FWFT FIFO controller driving one 18Kb half of TDP_RAM18KX2 (port A write, port B read).
module tdp18k_fifo_ctrl
    import tdp18k_fifo_pkg::*;
#(
    parameter int unsigned AF_THRESH = 1020,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              FLUSH,
    tdp18k_fifo_ctrl_if.slave bus,
    output logic              RAM_WEN_A,
    output logic [1:0]        RAM_BE_A,
    output logic [ADDR_W-1:0] RAM_ADDR_A,
    output logic [15:0]       RAM_WDATA_A,
    output logic [1:0]        RAM_WPARITY_A,
    output logic              RAM_REN_B,
    output logic [ADDR_W-1:0] RAM_ADDR_B,
    input  logic [15:0]       RAM_RDATA_B,
    input  logic [1:0]        RAM_RPARITY_B
);

    logic [PTR_W-1:0]  wptr, rptr;
    logic [CNT_W-1:0]  ram_cnt, ram_cnt_nxt, count, count_nxt;
    logic              inflight, wr_ready_q, af_q, ae_q;
    logic              push, pop, issue;
    logic [1:0]        buf_cnt, occ;
    logic [WORD_W-1:0] rd_word;
    fifo_word_t        head;
    logic              head_vld;

    // FLUSH masks the registered ready so nothing is accepted in the flush cycle itself.
    assign bus.WR_READY = wr_ready_q & ~FLUSH;
    assign push         = bus.WR_VALID & bus.WR_READY;
    assign pop          = head_vld & bus.RD_READY;

    // Buffer slots already committed (held + in flight) after this cycle's pop.
    assign occ   = buf_cnt + {1'b0, inflight} - {1'b0, pop};
    // ram_cnt is registered, so a word written this cycle is never read this cycle.
    assign issue = ~FLUSH & (ram_cnt != '0) & (occ < 2'd2);

    assign ram_cnt_nxt = FLUSH ? '0 : ram_cnt + CNT_W'(push) - CNT_W'(issue);
    assign count_nxt   = FLUSH ? '0 : count + CNT_W'(push) - CNT_W'(pop);

    assign RAM_WEN_A     = push;
    assign RAM_BE_A      = {2{push}};
    assign RAM_ADDR_A    = ram_addr(wptr);
    assign RAM_WDATA_A   = push ? bus.WR_DATA.data   : '0;
    assign RAM_WPARITY_A = push ? bus.WR_DATA.parity : '0;
    assign RAM_REN_B     = issue;
    assign RAM_ADDR_B    = ram_addr(rptr);
    assign rd_word       = {RAM_RPARITY_B, RAM_RDATA_B};

    assign bus.RD_DATA      = head;
    assign bus.RD_VALID     = head_vld;
    assign bus.COUNT        = count;
    assign bus.ALMOST_FULL  = af_q;
    assign bus.ALMOST_EMPTY = ae_q;

    // Pointers, occupancy, in-flight read tracking and registered status flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr       <= '0;
            rptr       <= '0;
            ram_cnt    <= '0;
            count      <= '0;
            inflight   <= 1'b0;
            wr_ready_q <= 1'b0;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
        end else begin
            if (FLUSH) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push)  wptr <= wptr + 1'b1;
                if (issue) rptr <= rptr + 1'b1;
            end
            ram_cnt    <= ram_cnt_nxt;
            count      <= count_nxt;
            inflight   <= issue;
            wr_ready_q <= ~FLUSH & (ram_cnt_nxt < CNT_W'(FIFO_DEPTH));
            af_q       <= count_nxt >= CNT_W'(AF_THRESH);
            ae_q       <= count_nxt <= CNT_W'(AE_THRESH);
        end
    end

    // Read data lands one cycle after REN; FLUSH drops both the buffer and any in-flight word.
    fifo_out_skid u_skid (
        .clk      (CLK),
        .rst_n    (RST_N),
        .clr      (FLUSH),
        .cap      (inflight),
        .cap_data (rd_word),
        .pop      (pop),
        .head     (head),
        .head_vld (head_vld),
        .buf_cnt  (buf_cnt)
    );

endmodule
